// File: rtl/ariane_pkg.sv
// ariane_pkg: types shared by the decode -> issue path.
//   scoreboard_entry_t : packed decoded instruction as carried between decode and issue
//   SBE_WIDTH          : bit width of scoreboard_entry_t
//   ID_BUF_DEPTH       : default number of entries in the ID/issue buffer
package ariane_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [7:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [3:0]  fu;
      logic        valid;
      logic [3:0]  rsvd;
   } scoreboard_entry_t;

   localparam int SBE_WIDTH    = $bits(scoreboard_entry_t);
   localparam int ID_BUF_DEPTH = 4;

endpackage

// File: rtl/id_issue_buffer_if.sv
// id_issue_if: decoder-side and issue-side handshake of the ID/issue buffer.
//   decoded_*        : entry offered by the decoder, decoded_ack returned by the buffer
//   issue_*          : head entry presented to issue, issue_instr_ack returned by issue
//   master modport   : the environment (decoder + issue stage)
//   slave modport    : the buffer
interface id_issue_if #(
   parameter int W = ariane_pkg::SBE_WIDTH
);
   logic [W-1:0] decoded_entry;
   logic         decoded_is_ctrl_flow;
   logic         decoded_valid;
   logic         decoded_ack;
   logic [W-1:0] issue_entry;
   logic         issue_entry_valid;
   logic         issue_is_ctrl_flow;
   logic         issue_instr_ack;

   modport master (
      output decoded_entry, decoded_is_ctrl_flow, decoded_valid, issue_instr_ack,
      input  decoded_ack, issue_entry, issue_entry_valid, issue_is_ctrl_flow
   );

   modport slave (
      input  decoded_entry, decoded_is_ctrl_flow, decoded_valid, issue_instr_ack,
      output decoded_ack, issue_entry, issue_entry_valid, issue_is_ctrl_flow
   );
endinterface

// File: rtl/id_issue_buffer_ring.sv
// id_ring_buffer: circular FIFO storage with read/write pointers and occupancy.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   flush_i          : empty the buffer at the next edge (push/pop that cycle are dropped)
//   push_i, data_i   : write data_i at the tail (caller guarantees space)
//   pop_i            : drop the head (caller guarantees non-empty)
//   head_o           : entry at the head slot (meaningless when empty)
//   occupancy_o      : number of entries held
module id_ring_buffer #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [W-1:0]               data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               head_o,
   output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0] occ_q, occ_d;

   // DEPTH is a power of two, so plain increment wraps DEPTH-1 -> 0.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         occ_d = occ_q + OW'(push_i) - OW'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage carries no reset so it maps onto distributed/block RAM.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i && !rst_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o      = mem_q[rd_ptr_q];
   assign occupancy_o = occ_q;
endmodule

// File: rtl/id_issue_buffer.sv
// id_issue_buffer: DEPTH-entry FIFO between decoder and issue stage.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   flush_i               : discard all buffered entries
//   decoded_*             : decoder offer; decoded_ack_o is combinational accept
//   issue_*               : head entry to issue; issue_instr_ack_i consumes it
//   occupancy_o           : entries held
//   cf_count_o            : control-flow entries held (capped at MAX_CF unless 0)
module id_issue_buffer
   import ariane_pkg::*;
#(
   parameter int DEPTH  = ID_BUF_DEPTH,
   parameter int SBE_W  = SBE_WIDTH,
   parameter int MAX_CF = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic [SBE_W-1:0]           decoded_entry_i,
   input  logic                       decoded_is_ctrl_flow_i,
   input  logic                       decoded_valid_i,
   output logic                       decoded_ack_o,
   output logic [SBE_W-1:0]           issue_entry_o,
   output logic                       issue_entry_valid_o,
   output logic                       issue_is_ctrl_flow_o,
   input  logic                       issue_instr_ack_i,
   output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
   output logic [$clog2(DEPTH+1)-1:0] cf_count_o
);
   localparam int OW = $clog2(DEPTH+1);

   logic [SBE_W:0]  head;      // {is_ctrl_flow, entry}
   logic [OW-1:0]   occ;
   logic [OW-1:0]   cf_count_q, cf_count_d;
   logic            deq, enq, space_ok, cf_ok;

   id_ring_buffer #(.DEPTH(DEPTH), .W(SBE_W + 1)) u_ring (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .push_i      (enq),
      .data_i      ({decoded_is_ctrl_flow_i, decoded_entry_i}),
      .pop_i       (deq),
      .head_o      (head),
      .occupancy_o (occ)
   );

   always_comb begin
      issue_entry_valid_o  = (occ != '0);
      issue_is_ctrl_flow_o = issue_entry_valid_o && head[SBE_W];
      // Zero when empty so the output is a clean 0 straight out of reset.
      issue_entry_o        = issue_entry_valid_o ? head[SBE_W-1:0] : '0;

      deq      = issue_instr_ack_i && issue_entry_valid_o;
      space_ok = (int'(occ) < DEPTH) || deq;
      // Retiring a control-flow head frees its cap slot in the same cycle.
      cf_ok    = !decoded_is_ctrl_flow_i || (MAX_CF == 0) ||
                 (int'(cf_count_q) < MAX_CF) || (deq && issue_is_ctrl_flow_o);
      enq      = decoded_valid_i && !flush_i && !rst_i && space_ok && cf_ok;
      decoded_ack_o = enq;

      cf_count_d = cf_count_q;
      if (flush_i) begin
         cf_count_d = '0;
      end else begin
         cf_count_d = cf_count_q + OW'(enq && decoded_is_ctrl_flow_i)
                                 - OW'(deq && issue_is_ctrl_flow_o);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cf_count_q <= '0;
      else       cf_count_q <= cf_count_d;
   end

   assign occupancy_o = occ;
   assign cf_count_o  = cf_count_q;
endmodule

// File: tb/tb_id_issue_buffer.sv
module tb_id_issue_buffer;
   localparam int DEPTH  = 4;
   localparam int W      = 64;
   localparam int MAX_CF = 1;

   logic clk = 1'b0;
   logic rst, flush;
   logic [2:0] occ, cfc;
   int total = 0;
   int bad   = 0;
   bit known = 0;

   logic [W:0] q[$];   // reference model: {cf, entry} in FIFO order

   always #5 clk = ~clk;

   id_issue_if #(.W(W)) bus ();

   id_issue_buffer #(.DEPTH(DEPTH), .SBE_W(W), .MAX_CF(MAX_CF)) dut (
      .clk_i                  (clk),
      .rst_i                  (rst),
      .flush_i                (flush),
      .decoded_entry_i        (bus.decoded_entry),
      .decoded_is_ctrl_flow_i (bus.decoded_is_ctrl_flow),
      .decoded_valid_i        (bus.decoded_valid),
      .decoded_ack_o          (bus.decoded_ack),
      .issue_entry_o          (bus.issue_entry),
      .issue_entry_valid_o    (bus.issue_entry_valid),
      .issue_is_ctrl_flow_o   (bus.issue_is_ctrl_flow),
      .issue_instr_ack_i      (bus.issue_instr_ack),
      .occupancy_o            (occ),
      .cf_count_o             (cfc)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int model_cf();
      int n = 0;
      foreach (q[i]) if (q[i][W]) n++;
      return n;
   endfunction

   task automatic drive(input bit r, input bit f, input bit v, input bit cf,
                        input logic [W-1:0] d, input bit a);
      rst = r; flush = f;
      bus.decoded_valid = v; bus.decoded_is_ctrl_flow = cf;
      bus.decoded_entry = d; bus.issue_instr_ack = a;
   endtask

   // One clock: check outputs against the model mid-cycle, then advance the model.
   task automatic cycle();
      bit head_cf, deq, exp_ack;
      int n;
      @(negedge clk);
      n       = q.size();
      head_cf = (n > 0) && q[0][W];
      deq     = bus.issue_instr_ack && (n > 0);
      exp_ack = !rst && bus.decoded_valid && !flush &&
                (n < DEPTH || deq) &&
                (!bus.decoded_is_ctrl_flow || MAX_CF == 0 || model_cf() < MAX_CF || (deq && head_cf));
      if (rst || known) chk("ack", 64'(bus.decoded_ack), 64'(exp_ack));
      if (known && !rst) begin
         chk("valid", 64'(bus.issue_entry_valid), 64'(n > 0));
         chk("occ",   64'(occ), 64'(n));
         chk("cfcnt", 64'(cfc), 64'(model_cf()));
         chk("headcf", 64'(bus.issue_is_ctrl_flow), 64'(head_cf));
         if (n > 0) chk("head", bus.issue_entry, q[0][W-1:0]);
      end
      $display("t=%0t rst=%0b fl=%0b v=%0b cf=%0b d=%h ack_in=%0b -> dack=%0b occ=%0d cfc=%0d",
               $time, rst, flush, bus.decoded_valid, bus.decoded_is_ctrl_flow,
               bus.decoded_entry, bus.issue_instr_ack, bus.decoded_ack, occ, cfc);
      @(posedge clk);
      if (rst || flush) begin
         q.delete();
         if (rst) known = 1;
      end else begin
         if (deq) void'(q.pop_front());
         if (exp_ack) q.push_back({bus.decoded_is_ctrl_flow, bus.decoded_entry});
      end
      #1;
   endtask

   initial begin
      drive(1, 0, 1, 0, 64'hDEAD, 0);
      repeat (2) cycle();
      chk("rst_valid", 64'(bus.issue_entry_valid), 64'd0);
      chk("rst_occ", 64'(occ), 64'd0);
      chk("rst_entry", bus.issue_entry, 64'd0);

      // Fill A..D, E refused while full, then E accepted alongside dequeue of A.
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 0, 64'hA0 + 64'(i), 0);
         cycle();
      end
      chk("full_occ", 64'(occ), 64'd4);
      drive(0, 0, 1, 0, 64'hE0, 0); cycle();
      drive(0, 0, 1, 0, 64'hE0, 1); cycle();
      chk("full_swap_occ", 64'(occ), 64'd4);
      chk("full_swap_head", bus.issue_entry, 64'hA1);

      // Drop one, then flush with valid and ack both asserted.
      drive(0, 0, 0, 0, 64'h0, 1); cycle();
      chk("pre_flush_occ", 64'(occ), 64'd3);
      drive(0, 1, 1, 1, 64'hF0, 1); cycle();
      chk("flush_occ", 64'(occ), 64'd0);
      chk("flush_valid", 64'(bus.issue_entry_valid), 64'd0);

      // Latency into an empty buffer.
      drive(0, 0, 1, 0, 64'h5A5A, 0); cycle();
      chk("lat_valid", 64'(bus.issue_entry_valid), 64'd1);
      chk("lat_entry", bus.issue_entry, 64'h5A5A);
      drive(0, 0, 0, 0, 64'h0, 1); cycle();

      // Control-flow cap: J held blocks K until J retires in the same cycle.
      drive(0, 0, 1, 1, 64'hB1, 0); cycle();
      drive(0, 0, 1, 1, 64'hB2, 0); cycle();
      drive(0, 0, 1, 1, 64'hB2, 1); cycle();
      chk("cf_swap_cnt", 64'(cfc), 64'd1);
      chk("cf_swap_head", bus.issue_entry, 64'hB2);

      // Randomised traffic across many pointer wraps.
      for (int i = 0; i < 300; i++) begin
         drive(0, ($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
               {$urandom, $urandom}, $urandom % 2);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
